// File: rtl/dcp_pkg.sv
// Shared constants, widths and reciprocal-ROM helpers for the dehaze
// radiance-recovery stage.
package dcp_pkg;
  localparam int OMEGA_DEF = 243;
  localparam int T0_DEF    = 26;
  localparam int PIX_W     = 8;
  localparam int X_W       = 16;
  localparam int RA_W      = 16;
  localparam int T_W       = 9;
  localparam int RT_W      = 12;
  localparam int P_W       = 21;

  // floor(65535/A); A=0 is treated as A=1.
  function automatic logic [RA_W-1:0] recip_a(input logic [PIX_W-1:0] a);
    logic [31:0] q;
    if (a == 8'd0) begin
      q = 32'd65535;
    end else begin
      q = 32'd65535 / {24'd0, a};
    end
    return q[RA_W-1:0];
  endfunction

  // floor(65536/t), saturated to the 12-bit ROM word for very small T0.
  function automatic logic [RT_W-1:0] recip_t(input logic [T_W-1:0] t);
    logic [31:0] q;
    if (t == 9'd0) begin
      q = 32'd65536;
    end else begin
      q = 32'd65536 / {23'd0, t};
    end
    if (q > 32'd4095) begin
      q = 32'd4095;
    end else begin
      q = q;
    end
    return q[RT_W-1:0];
  endfunction
endpackage

// File: rtl/dcp_recover_chan.sv
// One colour channel of the recovery: J = A + ((I - A) * rT) >>> 8,
// saturated to 0..255; two register stages, output forced to 0 when invalid.
module dcp_recover_chan
  import dcp_pkg::*;
(
  input  logic             pixelclk,
  input  logic             reset,
  input  logic             i_vld,
  input  logic [PIX_W-1:0] i_i,
  input  logic [PIX_W-1:0] i_a,
  input  logic [RT_W-1:0]  i_rt,
  output logic [PIX_W-1:0] o_j
);
  logic signed [8:0]     w_d;
  logic signed [P_W-1:0] w_p;
  logic signed [P_W-1:0] r_p;
  logic [PIX_W-1:0]      r_a;
  logic signed [12:0]    w_q;
  logic signed [13:0]    w_sum;
  logic [PIX_W-1:0]      w_j;

  assign w_d   = $signed({1'b0, i_i}) - $signed({1'b0, i_a});
  assign w_p   = $signed({{12{w_d[8]}}, w_d}) * $signed({9'd0, i_rt});
  // Taking the top bits of a two's-complement value is a floor division by 256.
  assign w_q   = $signed(r_p[20:8]);
  assign w_sum = $signed({6'd0, r_a}) + $signed({w_q[12], w_q});

  // Saturate the recovered value into the 8-bit pixel range.
  always_comb begin
    w_j = 8'd0;
    if (w_sum < 14'sd0) begin
      w_j = 8'd0;
    end else if (w_sum > 14'sd255) begin
      w_j = 8'd255;
    end else begin
      w_j = w_sum[7:0];
    end
  end

  // S5 product register and S6 output register.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      r_p <= 21'sd0;
      r_a <= 8'd0;
      o_j <= 8'd0;
    end else begin
      r_p <= w_p;
      r_a <= i_a;
      o_j <= i_vld ? w_j : 8'd0;
    end
  end
endmodule

// File: rtl/dcp_recover.sv
// Dark-channel-prior scene radiance recovery: 6-stage fixed-latency pipeline
// computing t = max(1 - w*dark/A, t0) and J = A + (I - A)/t per channel.
module dcp_recover
  import dcp_pkg::*;
#(
  parameter int OMEGA = OMEGA_DEF,
  parameter int T0    = T0_DEF
) (
  input  logic                 pixelclk,
  input  logic                 reset,
  input  logic [3*PIX_W-1:0]   i_rgb,
  input  logic [PIX_W-1:0]     i_dark,
  input  logic                 i_data_valid,
  input  logic                 i_vsync,
  input  logic [PIX_W-1:0]     i_atm,
  output logic [3*PIX_W-1:0]   o_rgb,
  output logic                 o_data_valid,
  output logic                 o_vsync
);
  localparam logic [PIX_W-1:0] OMEGA_C = 8'(OMEGA);
  localparam logic [T_W-1:0]   T0_C    = 9'(T0);
  localparam logic [X_W-1:0]   Y_MAX   = 16'(256 - T0);

  logic [RA_W-1:0]    w_rom_a [0:255];
  logic [RT_W-1:0]    w_rom_t [0:256];

  for (genvar g = 0; g < 256; g++) begin : g_rom_a
    assign w_rom_a[g] = recip_a(8'(g));
  end
  for (genvar g = 0; g < 257; g++) begin : g_rom_t
    assign w_rom_t[g] = recip_t(9'(g));
  end

  logic [PIX_W-1:0]   r_a_reg;
  logic [PIX_W-1:0]   w_a_sel;
  logic [PIX_W-1:0]   w_a_s;
  logic [X_W-1:0]     w_x;
  logic [31:0]        w_prod;
  logic [T_W-1:0]     w_t;
  logic [5:0]         r_vld_sr;
  logic [5:0]         r_vs_sr;
  logic [3*PIX_W-1:0] r_rgb1, r_rgb2, r_rgb3, r_rgb4;
  logic [PIX_W-1:0]   r_as1, r_as2, r_as3, r_as4;
  logic [X_W-1:0]     r_x;
  logic [RA_W-1:0]    r_ra;
  logic [X_W-1:0]     r_y;
  logic [T_W-1:0]     r_t;
  logic [RT_W-1:0]    r_rt;

  // A pixel arriving with the frame-start pulse already uses the new A.
  assign w_a_sel = i_vsync ? i_atm : r_a_reg;
  assign w_a_s   = (w_a_sel == 8'd0) ? 8'd1 : w_a_sel;
  assign w_x     = {8'd0, OMEGA_C} * {8'd0, i_dark};
  assign w_prod  = {16'd0, r_x} * {16'd0, r_ra};

  // S3 transmission with lower clamp.
  always_comb begin
    w_t = T0_C;
    if (r_y <= Y_MAX) begin
      w_t = 9'd256 - r_y[8:0];
    end else begin
      w_t = T0_C;
    end
  end

  // Frame A register, stages S1-S4 and the valid/vsync delay lines.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      r_a_reg  <= 8'd255;
      r_vld_sr <= 6'd0;
      r_vs_sr  <= 6'd0;
      r_rgb1   <= 24'd0;
      r_rgb2   <= 24'd0;
      r_rgb3   <= 24'd0;
      r_rgb4   <= 24'd0;
      r_as1    <= 8'd1;
      r_as2    <= 8'd1;
      r_as3    <= 8'd1;
      r_as4    <= 8'd1;
      r_x      <= 16'd0;
      r_ra     <= 16'd0;
      r_y      <= 16'd0;
      r_t      <= 9'd256;
      r_rt     <= 12'd256;
    end else begin
      r_a_reg  <= i_vsync ? i_atm : r_a_reg;
      r_vld_sr <= {r_vld_sr[4:0], i_data_valid};
      r_vs_sr  <= {r_vs_sr[4:0], i_vsync};
      r_rgb1   <= i_rgb;
      r_rgb2   <= r_rgb1;
      r_rgb3   <= r_rgb2;
      r_rgb4   <= r_rgb3;
      r_as1    <= w_a_s;
      r_as2    <= r_as1;
      r_as3    <= r_as2;
      r_as4    <= r_as3;
      r_x      <= w_x;
      r_ra     <= w_rom_a[w_a_s];
      r_y      <= w_prod[31:16];
      r_t      <= w_t;
      r_rt     <= w_rom_t[r_t];
    end
  end

  assign o_data_valid = r_vld_sr[5];
  assign o_vsync      = r_vs_sr[5];

  dcp_recover_chan u_chan_r (
    .pixelclk (pixelclk),
    .reset    (reset),
    .i_vld    (r_vld_sr[4]),
    .i_i      (r_rgb4[23:16]),
    .i_a      (r_as4),
    .i_rt     (r_rt),
    .o_j      (o_rgb[23:16])
  );

  dcp_recover_chan u_chan_g (
    .pixelclk (pixelclk),
    .reset    (reset),
    .i_vld    (r_vld_sr[4]),
    .i_i      (r_rgb4[15:8]),
    .i_a      (r_as4),
    .i_rt     (r_rt),
    .o_j      (o_rgb[15:8])
  );

  dcp_recover_chan u_chan_b (
    .pixelclk (pixelclk),
    .reset    (reset),
    .i_vld    (r_vld_sr[4]),
    .i_i      (r_rgb4[7:0]),
    .i_a      (r_as4),
    .i_rt     (r_rt),
    .o_j      (o_rgb[7:0])
  );
endmodule

// File: tb/tb_dcp_recover.sv
// Scoreboard bench for dcp_recover: directed cases plus randomized traffic
// against an arithmetic reference of the recovery equations.
module tb_dcp_recover;
  localparam int OMEGA = 243;
  localparam int T0    = 26;

  logic        pixelclk = 1'b0;
  logic        reset;
  logic [23:0] i_rgb;
  logic [7:0]  i_dark;
  logic        i_data_valid;
  logic        i_vsync;
  logic [7:0]  i_atm;
  logic [23:0] o_rgb;
  logic        o_data_valid;
  logic        o_vsync;

  dcp_recover #(.OMEGA(OMEGA), .T0(T0)) dut (
    .pixelclk     (pixelclk),
    .reset        (reset),
    .i_rgb        (i_rgb),
    .i_dark       (i_dark),
    .i_data_valid (i_data_valid),
    .i_vsync      (i_vsync),
    .i_atm        (i_atm),
    .o_rgb        (o_rgb),
    .o_data_valid (o_data_valid),
    .o_vsync      (o_vsync)
  );

  always #5 pixelclk = ~pixelclk;

  typedef struct {
    int          cyc;
    logic [23:0] rgb;
    bit          vs;
    bit          dv;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;
  int   a_model = 255;
  bit   mon_en  = 1'b0;

  always @(posedge pixelclk) cyc <= cyc + 1;

  // Reference recovery: t from the dark-channel prior, J = A + (I-A)/t.
  function automatic logic [23:0] ref_pix(input logic [23:0] rgb, input int dark, input int atm);
    int a, ra, y, t, rt, d, p, qv, j;
    logic [23:0] r;
    a  = (atm == 0) ? 1 : atm;
    ra = 65535 / a;
    y  = int'((longint'(OMEGA * dark) * longint'(ra)) >>> 16);
    t  = (y <= 256 - T0) ? 256 - y : T0;
    rt = 65536 / t;
    r  = 24'd0;
    for (int c = 0; c < 3; c++) begin
      d  = int'(rgb[c*8 +: 8]) - a;
      p  = d * rt;
      qv = p >>> 8;
      j  = a + qv;
      if (j < 0) j = 0;
      if (j > 255) j = 255;
      r[c*8 +: 8] = 8'(j);
    end
    return r;
  endfunction

  task automatic drive(input logic [23:0] rgb, input logic [7:0] dark, input bit dv,
                       input bit vs, input logic [7:0] atm, input bit use_exp,
                       input logic [23:0] exp_rgb);
    exp_t e;
    @(negedge pixelclk);
    reset        = 1'b0;
    i_rgb        = rgb;
    i_dark       = dark;
    i_data_valid = dv;
    i_vsync      = vs;
    i_atm        = atm;
    if (vs) a_model = int'(atm);
    if (dv || vs) begin
      e.cyc = cyc + 6;
      e.vs  = vs;
      e.dv  = dv;
      e.rgb = dv ? (use_exp ? exp_rgb : ref_pix(rgb, int'(dark), a_model)) : 24'd0;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    drive(24'd0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 24'd0);
  endtask

  task automatic do_reset();
    @(negedge pixelclk);
    reset        = 1'b1;
    i_data_valid = 1'b0;
    i_vsync      = 1'b0;
    #1;
    while (q.size() > 0 && q[$].cyc > cyc) q.pop_back();
    a_model = 255;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  initial begin
    exp_t e;
    forever begin
      @(negedge pixelclk);
      if (mon_en) begin
        if (o_data_valid || o_vsync) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output cyc=%0d got dv=%b vs=%b rgb=%h, required no output",
                     cyc, o_data_valid, o_vsync, o_rgb);
          end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.dv != o_data_valid || e.vs != o_vsync) begin
              errors++;
              $display("FAIL timing cyc=%0d got dv=%b vs=%b, required dv=%b vs=%b at cyc=%0d",
                       cyc, o_data_valid, o_vsync, e.dv, e.vs, e.cyc);
            end
            if (e.dv && o_data_valid) begin
              checks++;
              if (o_rgb !== e.rgb) begin
                errors++;
                $display("FAIL pixel cyc=%0d got %h, required %h", cyc, o_rgb, e.rgb);
              end
            end
          end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_output cyc=%0d got none, required dv=%b vs=%b rgb=%h",
                   cyc, q[0].dv, q[0].vs, q[0].rgb);
          void'(q.pop_front());
        end
        if (!o_data_valid) begin
          checks++;
          if (o_rgb !== 24'd0) begin
            errors++;
            $display("FAIL idle_zero cyc=%0d got %h, required 000000", cyc, o_rgb);
          end
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    i_rgb        = 24'd0;
    i_dark       = 8'd0;
    i_data_valid = 1'b0;
    i_vsync      = 1'b0;
    i_atm        = 8'd0;
    repeat (3) @(negedge pixelclk);
    checks += 3;
    if (o_rgb !== 24'd0) begin errors++; $display("FAIL reset_rgb got %h, required 000000", o_rgb); end
    if (o_data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b, required 0", o_data_valid); end
    if (o_vsync !== 1'b0) begin errors++; $display("FAIL reset_vs got %b, required 0", o_vsync); end
    mon_en = 1'b1;

    // Identity at zero dark with A=200 latched on the same cycle.
    drive(24'h96DC64, 8'd0, 1'b1, 1'b1, 8'd200, 1'b1, 24'h96DC64);
    idle();
    // Nominal and clamp/saturate cases at A=200.
    drive(24'h96DC64, 8'd100, 1'b1, 1'b0, 8'd7, 1'b1, 24'h69ED0A);
    drive(24'hFFC800, 8'd200, 1'b1, 1'b0, 8'd9, 1'b1, 24'hFFC800);
    idle();
    // A update mid-stream on continuous valid pixels.
    for (int i = 0; i < 12; i++) begin
      drive(24'($urandom), 8'($urandom_range(0, 255)), 1'b1, (i == 5), (i < 5) ? 8'd200 : 8'd100,
            1'b0, 24'd0);
    end
    // A=0 behaves as A=1.
    drive(24'h102030, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1, 24'h102030);
    // Empty frame: vsync alone still propagates.
    drive(24'd0, 8'd0, 1'b0, 1'b1, 8'd200, 1'b0, 24'd0);
    repeat (3) idle();
    // Reset with pixels in flight, then A must be back to 255.
    for (int i = 0; i < 6; i++) begin
      drive(24'($urandom), 8'($urandom_range(0, 255)), 1'b1, 1'b0, 8'd0, 1'b0, 24'd0);
    end
    do_reset();
    drive(24'h96DC64, 8'd100, 1'b1, 1'b0, 8'd0, 1'b1, 24'h58C708);
    repeat (8) idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(24'($urandom), 8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)), 1'b0, 24'd0);
    end

    for (int i = 0; i < 20 && q.size() > 0; i++) idle();
    repeat (2) @(negedge pixelclk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d outstanding, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
